// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared state codes, light encodings and head decode for the intersection scheduler
package traffic_pkg;

    typedef enum logic [2:0] {
        NS_G   = 3'd0,
        NS_Y   = 3'd1,
        RED_EW = 3'd2,
        EW_G   = 3'd3,
        EW_Y   = 3'd4,
        RED_NS = 3'd5
    } state_t;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    // {light_ns, light_ew} for a given state; every non-listed state is all-red
    function automatic logic [5:0] heads_of(input state_t s);
        logic [5:0] h;
        case (s)
            NS_G:    h = {L_GRN, L_RED};
            NS_Y:    h = {L_YEL, L_RED};
            EW_G:    h = {L_RED, L_GRN};
            EW_Y:    h = {L_RED, L_YEL};
            default: h = {L_RED, L_RED};
        endcase
        return h;
    endfunction

endpackage

// File: rtl/approach_queue.sv
// rtl/approach_queue.sv - per-approach arrival edge detector and saturating waiting-car counter
module approach_queue #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         detect,
    input  logic         drain,
    output logic [W-1:0] count
);

    logic prev;
    logic rise;
    logic dec;

    assign rise = detect & ~prev;
    assign dec  = drain & (count != '0);

    // Edge history; cleared on reset so a detector held high across reset counts once
    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= detect;
        end
    end

    // Arrival and discharge in the same cycle cancel; both ends saturate
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else begin
            case ({rise, dec})
                2'b10: if (count != '1) count <= count + 1'b1;
                2'b01: count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// rtl/traffic_phase_scheduler.sv - demand-actuated two-axis signal phase FSM with per-approach queues
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 6,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1,
    parameter int W         = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         tick,
    input  logic         detect_ns,
    input  logic         detect_sn,
    input  logic         detect_ew,
    input  logic         detect_we,
    output logic [2:0]   light_ns,
    output logic [2:0]   light_ew,
    output logic [2:0]   phase,
    output logic         phase_chg,
    output logic [W-1:0] wait_ns,
    output logic [W-1:0] wait_sn,
    output logic [W-1:0] wait_ew,
    output logic [W-1:0] wait_we
);

    // The timer only has to reach the longest interval any state compares against
    localparam int T_A   = (MAX_GREEN > YELLOW_T) ? MAX_GREEN : YELLOW_T;
    localparam int T_SAT = (T_A > ALLRED_T) ? T_A : ALLRED_T;
    localparam int TW    = $clog2(T_SAT + 1);

    localparam logic [TW-1:0] SAT_V = TW'(T_SAT);
    localparam logic [TW-1:0] MIN_V = TW'(MIN_GREEN);
    localparam logic [TW-1:0] MAX_V = TW'(MAX_GREEN);
    localparam logic [TW-1:0] YEL_V = TW'(YELLOW_T);
    localparam logic [TW-1:0] AR_V  = TW'(ALLRED_T);

    state_t        state;
    state_t        nxt;
    logic          go;
    logic [TW-1:0] timer;
    logic [TW-1:0] elapsed;
    logic          dem_ns;
    logic          dem_ew;
    logic          drain_ns;
    logic          drain_ew;

    assign phase    = state;
    assign drain_ns = tick & (state == NS_G);
    assign drain_ew = tick & (state == EW_G);

    approach_queue #(.W(W)) u_q_ns (.clock(clock), .reset(reset), .detect(detect_ns), .drain(drain_ns), .count(wait_ns));
    approach_queue #(.W(W)) u_q_sn (.clock(clock), .reset(reset), .detect(detect_sn), .drain(drain_ns), .count(wait_sn));
    approach_queue #(.W(W)) u_q_ew (.clock(clock), .reset(reset), .detect(detect_ew), .drain(drain_ew), .count(wait_ew));
    approach_queue #(.W(W)) u_q_we (.clock(clock), .reset(reset), .detect(detect_we), .drain(drain_ew), .count(wait_we));

    // Elapsed counts the tick under evaluation; demand comes from the registered queues
    always_comb begin
        elapsed = (timer == SAT_V) ? timer : timer + 1'b1;
        dem_ns  = (wait_ns != '0) | (wait_sn != '0);
        dem_ew  = (wait_ew != '0) | (wait_we != '0);
    end

    // Next-state decision, only acted on in a tick cycle
    always_comb begin
        nxt = state;
        go  = 1'b0;
        case (state)
            NS_G: if (elapsed >= MIN_V && dem_ew && (!dem_ns || elapsed >= MAX_V)) begin
                nxt = NS_Y;
                go  = 1'b1;
            end
            NS_Y: if (elapsed == YEL_V) begin
                nxt = RED_EW;
                go  = 1'b1;
            end
            RED_EW: if (elapsed == AR_V) begin
                nxt = EW_G;
                go  = 1'b1;
            end
            EW_G: if (elapsed >= MIN_V && dem_ns && (!dem_ew || elapsed >= MAX_V)) begin
                nxt = EW_Y;
                go  = 1'b1;
            end
            EW_Y: if (elapsed == YEL_V) begin
                nxt = RED_NS;
                go  = 1'b1;
            end
            RED_NS: if (elapsed == AR_V) begin
                nxt = NS_G;
                go  = 1'b1;
            end
            default: begin
                nxt = RED_NS;
                go  = 1'b1;
            end
        endcase
    end

    // Phase FSM: state, dwell timer, registered light heads and entry pulse move together
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= RED_NS;
            timer     <= '0;
            light_ns  <= L_RED;
            light_ew  <= L_RED;
            phase_chg <= 1'b0;
        end else begin
            phase_chg <= 1'b0;
            if (tick) begin
                if (go) begin
                    state                <= nxt;
                    timer                <= '0;
                    phase_chg            <= 1'b1;
                    {light_ns, light_ew} <= heads_of(nxt);
                end else begin
                    timer <= elapsed;
                end
            end
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// tb/tb_traffic_phase_scheduler.sv - directed self-checking bench for traffic_phase_scheduler
module tb_traffic_phase_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick  = 1'b0;
    logic       detect_ns = 1'b0, detect_sn = 1'b0, detect_ew = 1'b0, detect_we = 1'b0;
    logic [2:0] light_ns, light_ew, phase;
    logic       phase_chg;
    logic [3:0] wait_ns, wait_sn, wait_ew, wait_we;

    int vectors    = 0;
    int miscompares = 0;

    // det bit order: {ns, sn, ew, we}
    localparam logic [3:0] D_NS = 4'b1000;
    localparam logic [3:0] D_SN = 4'b0100;
    localparam logic [3:0] D_EW = 4'b0010;
    localparam logic [3:0] D_WE = 4'b0001;

    always #5 clock = ~clock;

    traffic_phase_scheduler #(
        .MIN_GREEN(3), .MAX_GREEN(6), .YELLOW_T(2), .ALLRED_T(1), .W(4)
    ) dut (
        .clock(clock), .reset(reset), .tick(tick),
        .detect_ns(detect_ns), .detect_sn(detect_sn), .detect_ew(detect_ew), .detect_we(detect_we),
        .light_ns(light_ns), .light_ew(light_ew), .phase(phase), .phase_chg(phase_chg),
        .wait_ns(wait_ns), .wait_sn(wait_sn), .wait_ew(wait_ew), .wait_we(wait_we)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One clock with the given tick and detector levels; returns 1 time unit after the edge
    task automatic cyc(input logic tk, input logic [3:0] det);
        tick = tk;
        {detect_ns, detect_sn, detect_ew, detect_we} = det;
        @(posedge clock);
        #1;
        tick = 1'b0;
    endtask

    task automatic do_tick();
        cyc(1'b1, 4'b0000);
        cyc(1'b0, 4'b0000);
    endtask

    task automatic edge_on(input logic [3:0] det);
        cyc(1'b0, det);
        cyc(1'b0, 4'b0000);
    endtask

    task automatic reset_pulse();
        reset = 1'b1;
        cyc(1'b0, 4'b0000);
        reset = 1'b0;
    endtask

    int pulses;
    int exp_cycle [18] = '{0,0,0,0,0,1, 1,2,3, 3,3,3,3,3,4, 4,5,0};

    initial begin
        // 1. reset state, first tick, indefinite green without opposing demand
        cyc(1'b0, 4'b0000);
        cyc(1'b0, 4'b0000);
        chk("rst_phase", phase, 5);
        chk("rst_light_ns", light_ns, 3'b100);
        chk("rst_light_ew", light_ew, 3'b100);
        chk("rst_chg", phase_chg, 0);
        chk("rst_waits", {wait_ns, wait_sn, wait_ew, wait_we}, 0);
        reset = 1'b0;
        cyc(1'b0, 4'b0000);
        chk("idle_phase", phase, 5);
        cyc(1'b1, 4'b0000);
        chk("first_tick_phase", phase, 0);
        chk("first_tick_ns", light_ns, 3'b001);
        chk("first_tick_ew", light_ew, 3'b100);
        chk("first_tick_chg", phase_chg, 1);
        cyc(1'b0, 4'b0000);
        chk("chg_one_cycle", phase_chg, 0);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 4'b0000);
            pulses += int'(phase_chg);
            cyc(1'b0, 4'b0000);
        end
        chk("hold_phase", phase, 0);
        chk("hold_pulses", pulses, 0);

        // 2. single EW arrival at NS_G elapsed 1
        reset_pulse();
        cyc(1'b1, 4'b0000);
        chk("t2_ns_g", phase, 0);
        cyc(1'b1, D_EW);
        cyc(1'b0, 4'b0000);
        chk("t2_wait_ew", wait_ew, 1);
        do_tick();
        chk("t2_e2_green", phase, 0);
        cyc(1'b1, 4'b0000);
        chk("t2_e3_yellow", phase, 1);
        chk("t2_y_ns", light_ns, 3'b010);
        chk("t2_y_ew", light_ew, 3'b100);
        chk("t2_y_chg", phase_chg, 1);
        cyc(1'b0, 4'b0000);
        do_tick();
        chk("t2_y1", phase, 1);
        do_tick();
        chk("t2_red_ew", phase, 2);
        chk("t2_red_heads", {light_ns, light_ew}, 6'b100100);
        do_tick();
        chk("t2_ew_g", phase, 3);
        chk("t2_ew_light", light_ew, 3'b001);
        chk("t2_wait_before", wait_ew, 1);
        do_tick();
        chk("t2_wait_after", wait_ew, 0);
        chk("t2_ew_holds", phase, 3);

        // 3. both axes loaded at NS_G entry: max green, six discharged
        reset_pulse();
        cyc(1'b1, 4'b0000);
        edge_on(D_NS | D_EW);
        for (int i = 0; i < 14; i++) edge_on(D_NS);
        chk("t3_wait_ns", wait_ns, 15);
        chk("t3_wait_ew", wait_ew, 1);
        for (int i = 0; i < 5; i++) do_tick();
        chk("t3_e5_green", phase, 0);
        chk("t3_e5_wait", wait_ns, 10);
        do_tick();
        chk("t3_e6_yellow", phase, 1);
        chk("t3_wait_ns_end", wait_ns, 9);

        // 4. saturation and coincident arrival/discharge
        for (int i = 0; i < 20; i++) edge_on(D_WE);
        chk("t4_sat", wait_we, 15);
        do_tick();
        do_tick();
        do_tick();
        chk("t4_ew_g", phase, 3);
        cyc(1'b1, D_WE);
        chk("t4_coinc_sat", wait_we, 15);
        chk("t4_ew_drain", wait_ew, 0);
        cyc(1'b0, 4'b0000);
        do_tick();
        chk("t4_drain", wait_we, 14);
        cyc(1'b1, D_WE);
        chk("t4_coinc", wait_we, 14);
        cyc(1'b0, 4'b0000);

        // 5. reset in EW_Y with queues loaded
        do_tick();
        do_tick();
        chk("t5_e5_green", phase, 3);
        do_tick();
        chk("t5_ew_y", phase, 4);
        chk("t5_ew_y_light", light_ew, 3'b010);
        chk("t5_wait_we", wait_we, 11);
        chk("t5_wait_ns", wait_ns, 9);
        reset = 1'b1;
        cyc(1'b1, 4'b0000);
        chk("t5_rst_phase", phase, 5);
        chk("t5_rst_heads", {light_ns, light_ew}, 6'b100100);
        chk("t5_rst_waits", {wait_ns, wait_sn, wait_ew, wait_we}, 0);
        chk("t5_rst_chg", phase_chg, 0);

        // 6. detector high across reset release, then continuous two-axis demand
        cyc(1'b0, D_SN);
        reset = 1'b0;
        cyc(1'b0, D_SN);
        chk("t6_held_detector", wait_sn, 1);
        cyc(1'b0, 4'b0000);
        for (int i = 0; i < 15; i++) edge_on(D_NS | D_EW);
        chk("t6_load", {wait_ns, wait_ew}, 8'hFF);
        cyc(1'b1, 4'b0000);
        chk("t6_entry", phase, 0);
        cyc(1'b0, 4'b0000);
        for (int k = 0; k < 36; k++) begin
            cyc(1'b1, 4'b0000);
            chk($sformatf("t6_phase_%0d", k + 1), phase, exp_cycle[k % 18]);
            chk($sformatf("t6_excl_%0d", k + 1), (light_ns == 3'b100) || (light_ew == 3'b100), 1);
            cyc(1'b0, 4'b0000);
        end
        chk("t6_ns_left", wait_ns, 3);
        chk("t6_ew_left", wait_ew, 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
